// File: rtl/alu_board_sequencer.sv
// Board-level ALU test sequencer: debounced keys, operand/op capture around an
// external combinational ALU, and a browsable ring buffer of recent results.
module alu_board_sequencer #(
  parameter int DATA_W        = 32,
  parameter int IN_W          = 16,
  parameter int HIST_DEPTH    = 8,
  parameter int DEB_CYCLES    = 65536,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                            CLK,
  input  logic                            nRST,
  input  logic [2:0]                      key_n,
  input  logic [IN_W-1:0]                 sw_data,
  input  logic                            sw_sext,
  input  logic [3:0]                      sw_op,
  input  logic [DATA_W-1:0]               alu_out,
  input  logic [2:0]                      alu_flags,
  output logic [DATA_W-1:0]               alu_a,
  output logic [DATA_W-1:0]               alu_b,
  output logic [3:0]                      alu_op,
  output logic [DATA_W-1:0]               disp_data,
  output logic [2:0]                      disp_flags,
  output logic [$clog2(HIST_DEPTH+1)-1:0] hist_count,
  output logic [$clog2(HIST_DEPTH)-1:0]   view_idx,
  output logic                            busy
);

  localparam int CNT_W = $clog2(HIST_DEPTH+1);
  localparam int IDX_W = $clog2(HIST_DEPTH);
  localparam int DEB_W = $clog2(DEB_CYCLES+1);
  localparam int STL_W = $clog2(SETTLE_CYCLES+1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

  state_t state, state_nx;

  logic [2:0]       sync1, sync2, acc, pulse;
  logic [DEB_W-1:0] deb_cnt [3];

  logic [STL_W-1:0]  settle_cnt;
  logic [IDX_W-1:0]  wr_ptr, rd_ptr, next_view;
  logic [CNT_W-1:0]  view_inc;
  logic [DATA_W-1:0] ext;
  logic [DATA_W+2:0] hist [HIST_DEPTH];

  logic ld_p, ex_p, br_p;
  assign ld_p = pulse[0];
  assign ex_p = pulse[1];
  assign br_p = pulse[2];

  // Per-key synchronizer and debouncer; a press emits one registered pulse
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      sync1 <= '1;
      sync2 <= '1;
      acc   <= '1;
      pulse <= '0;
      for (int unsigned k = 0; k < 3; k++) deb_cnt[k] <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      for (int unsigned k = 0; k < 3; k++) begin
        pulse[k] <= 1'b0;
        if (sync2[k] != acc[k]) begin
          if (deb_cnt[k] == DEB_W'(DEB_CYCLES-1)) begin
            acc[k]     <= sync2[k];
            deb_cnt[k] <= '0;
            pulse[k]   <= ~sync2[k];
          end else begin
            deb_cnt[k] <= deb_cnt[k] + DEB_W'(1);
          end
        end else begin
          deb_cnt[k] <= '0;
        end
      end
    end
  end

  // Operand extension, display read pointer and browse wrap computation
  always_comb begin
    ext       = {{(DATA_W-IN_W){sw_sext & sw_data[IN_W-1]}}, sw_data};
    rd_ptr    = wr_ptr - IDX_W'(1) - view_idx;
    view_inc  = CNT_W'(view_idx) + CNT_W'(1);
    next_view = (view_inc >= hist_count) ? '0 : view_inc[IDX_W-1:0];
  end

  // Sequencer state register
  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nx;
  end

  // Sequencer next-state and busy decode
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      IDLE:    if (ex_p) state_nx = SETTLE;
      SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == STL_W'(SETTLE_CYCLES-1)) state_nx = CAPTURE;
      end
      CAPTURE: begin
        busy     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand registers, settle timer, history ring buffer and display register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      settle_cnt <= '0;
      wr_ptr     <= '0;
      hist_count <= '0;
      view_idx   <= '0;
      disp_data  <= '0;
      disp_flags <= '0;
      for (int unsigned i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
    end else begin
      if (hist_count == '0) {disp_data, disp_flags} <= '0;
      else                  {disp_data, disp_flags} <= hist[rd_ptr];

      case (state)
        IDLE: begin
          settle_cnt <= '0;
          // exec beats load beats browse; losers are simply dropped
          if (ex_p) begin
            alu_a  <= ext;
            alu_op <= sw_op;
          end else if (ld_p) begin
            alu_b <= ext;
          end else if (br_p && hist_count != '0) begin
            view_idx <= next_view;
          end
        end
        SETTLE: settle_cnt <= settle_cnt + STL_W'(1);
        CAPTURE: begin
          hist[wr_ptr] <= {alu_out, alu_flags};
          wr_ptr       <= wr_ptr + IDX_W'(1);
          if (hist_count != CNT_W'(HIST_DEPTH)) hist_count <= hist_count + CNT_W'(1);
          view_idx     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_board_sequencer.sv
// Self-checking bench for alu_board_sequencer with a queue-based history model.
module tb_alu_board_sequencer;

  localparam int DW = 32;
  localparam int IW = 16;
  localparam int HD = 8;
  localparam int DEB = 4;
  localparam int ST = 16;

  logic          CLK;
  logic          nRST;
  logic [2:0]    key_n;
  logic [IW-1:0] sw_data;
  logic          sw_sext;
  logic [3:0]    sw_op;
  logic [DW-1:0] alu_out;
  logic [2:0]    alu_flags;
  logic [DW-1:0] alu_a, alu_b, disp_data;
  logic [3:0]    alu_op;
  logic [2:0]    disp_flags;
  logic [3:0]    hist_count;
  logic [2:0]    view_idx;
  logic          busy;

  alu_board_sequencer #(
    .DATA_W(DW), .IN_W(IW), .HIST_DEPTH(HD), .DEB_CYCLES(DEB), .SETTLE_CYCLES(ST)
  ) dut (
    .CLK(CLK), .nRST(nRST), .key_n(key_n), .sw_data(sw_data), .sw_sext(sw_sext),
    .sw_op(sw_op), .alu_out(alu_out), .alu_flags(alu_flags), .alu_a(alu_a),
    .alu_b(alu_b), .alu_op(alu_op), .disp_data(disp_data), .disp_flags(disp_flags),
    .hist_count(hist_count), .view_idx(view_idx), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference ALU: {result, negative, overflow, zero}
  function automatic logic [34:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [3:0] op);
    logic [31:0] r;
    logic        v;
    v = 1'b0;
    case (op)
      4'd0: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      default: r = a;
    endcase
    return {r, r[31], v, (r == 32'd0)};
  endfunction

  always_comb {alu_out, alu_flags} = alu_ref(alu_a, alu_b, alu_op);

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Model state
  logic [34:0] q[$];
  logic [31:0] m_a, m_b;
  logic [3:0]  m_op;
  int          m_view;

  function automatic logic [31:0] ext_of(logic [15:0] d, logic s);
    return s ? {{16{d[15]}}, d} : {16'd0, d};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press(logic [2:0] mask, int hold);
    key_n = ~mask;
    step(hold);
    key_n = 3'b111;
    step(40);
  endtask

  task automatic m_reset();
    q.delete();
    m_a = '0; m_b = '0; m_op = '0; m_view = 0;
  endtask

  task automatic m_exec(logic [15:0] d, logic s, logic [3:0] op);
    m_a  = ext_of(d, s);
    m_op = op;
    q.push_front(alu_ref(m_a, m_b, op));
    if (q.size() > HD) void'(q.pop_back());
    m_view = 0;
  endtask

  task automatic m_browse();
    if (q.size() > 0) m_view = (m_view + 1) % q.size();
  endtask

  task automatic set_sw(logic [15:0] d, logic s, logic [3:0] op);
    sw_data = d; sw_sext = s; sw_op = op;
  endtask

  task automatic do_load(logic [15:0] d, logic s);
    set_sw(d, s, 4'd0);
    press(3'b001, 10);
    m_b = ext_of(d, s);
  endtask

  task automatic do_exec(logic [15:0] d, logic s, logic [3:0] op);
    set_sw(d, s, op);
    press(3'b010, 10);
    m_exec(d, s, op);
  endtask

  task automatic do_browse();
    press(3'b100, 10);
    m_browse();
  endtask

  task automatic check_all(string tag);
    logic [34:0] e;
    e = (q.size() == 0) ? 35'd0 : q[m_view];
    check({tag, ".hist_count"}, 64'(hist_count), 64'(q.size()));
    check({tag, ".view_idx"},   64'(view_idx),   64'(m_view));
    check({tag, ".disp_data"},  64'(disp_data),  64'(e[34:3]));
    check({tag, ".disp_flags"}, 64'(disp_flags), 64'(e[2:0]));
    check({tag, ".alu_a"},      64'(alu_a),      64'(m_a));
    check({tag, ".alu_b"},      64'(alu_b),      64'(m_b));
    check({tag, ".alu_op"},     64'(alu_op),     64'(m_op));
    check({tag, ".busy"},       64'(busy),       64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, blen, wr, seen, hc0;
    logic [31:0] d_at_wr, d_after;
    logic [2:0]  f_after;

    m_reset();
    set_sw(16'd0, 1'b0, 4'd0);

    // Reset with all keys held low
    nRST = 1'b0;
    key_n = 3'b000;
    step(3);
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.hist_count", 64'(hist_count), 64'(0));
    check("rst.disp_data", 64'(disp_data), 64'(0));
    check("rst.alu_b", 64'(alu_b), 64'(0));
    nRST = 1'b1;
    key_n = 3'b111;
    step(40);
    check_all("after_rst");

    // Extension
    do_load(16'h8001, 1'b1);
    check("sext.alu_b", 64'(alu_b), 64'h0000_0000_FFFF_8001);
    do_load(16'h8001, 1'b0);
    check("zext.alu_b", 64'(alu_b), 64'h0000_0000_0000_8001);

    // 5 + 3 with latency / busy measurement
    do_load(16'd5, 1'b0);
    set_sw(16'd3, 1'b0, 4'd0);
    key_n = 3'b101;
    first = -1; blen = 0; wr = -1; d_at_wr = '1; d_after = '1; f_after = '1;
    for (int c = 1; c <= 60; c++) begin
      step(1);
      if (c == 10) key_n = 3'b111;
      if (busy) begin
        if (first < 0) first = c;
        blen++;
      end
      if (wr >= 0 && c == wr + 1) begin d_after = disp_data; f_after = disp_flags; end
      if (wr < 0 && hist_count != 0) begin wr = c; d_at_wr = disp_data; end
    end
    step(10);
    m_exec(16'd3, 1'b0, 4'd0);
    check("add.busy_seen", 64'(first > 0), 64'(1));
    check("add.busy_len", 64'(blen), 64'(ST + 1));
    check("add.write_delay", 64'(wr - first), 64'(ST + 1));
    check("add.disp_at_write", 64'(d_at_wr), 64'(0));
    check("add.disp_after", 64'(d_after), 64'(8));
    check("add.flags_after", 64'(f_after), 64'(0));
    check_all("add");

    // 3-cycle glitch: nothing; then a real press: one capture
    key_n = 3'b101;
    step(3);
    key_n = 3'b111;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      step(1);
      if (busy) seen = 1;
    end
    check("glitch.busy", 64'(seen), 64'(0));
    check_all("glitch");
    do_exec(16'd7, 1'b0, 4'd1);
    check_all("after_glitch");

    // Ten results 1..10 with history wrap and browsing
    do_load(16'd0, 1'b0);
    for (int i = 1; i <= 10; i++) do_exec(16'(i), 1'b0, 4'd0);
    check("wrap.hist_count", 64'(hist_count), 64'(8));
    check("wrap.disp", 64'(disp_data), 64'(10));
    for (int i = 0; i < 7; i++) do_browse();
    check("browse7.disp", 64'(disp_data), 64'(3));
    do_browse();
    check("browse8.disp", 64'(disp_data), 64'(10));
    check_all("browse");

    // Simultaneous pulses: exec beats load and browse; load beats browse
    do_browse();
    set_sw(16'h1234, 1'b0, 4'd4);
    press(3'b111, 10);
    m_exec(16'h1234, 1'b0, 4'd4);
    check_all("prio_all");
    do_browse();
    set_sw(16'hF00F, 1'b1, 4'd0);
    press(3'b101, 10);
    m_b = ext_of(16'hF00F, 1'b1);
    check_all("prio_ld_br");

    // Exec+load pulses while busy are dropped; switches change mid-sequence
    hc0 = int'(hist_count);
    set_sw(16'h00AA, 1'b0, 4'd3);
    key_n = 3'b101;
    step(5);
    key_n = 3'b111;
    step(6);
    set_sw(16'h5555, 1'b1, 4'd2);
    key_n = 3'b100;
    step(8);
    key_n = 3'b111;
    step(50);
    m_exec(16'h00AA, 1'b0, 4'd3);
    check("busydrop.count", 64'(hist_count), 64'((hc0 + 1 > HD) ? HD : hc0 + 1));
    check_all("busydrop");

    // Reset during SETTLE aborts the sequence
    set_sw(16'h0042, 1'b0, 4'd0);
    key_n = 3'b101;
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      step(1);
      if (busy) seen = 1;
    end
    check("rstmid.busy_seen", 64'(seen), 64'(1));
    key_n = 3'b111;
    step(2);
    nRST = 1'b0;
    step(1);
    nRST = 1'b1;
    m_reset();
    check("rstmid.busy", 64'(busy), 64'(0));
    check("rstmid.hist_count", 64'(hist_count), 64'(0));
    step(1);
    check("rstmid.disp", 64'(disp_data), 64'(0));
    step(40);
    check_all("rstmid");
    do_exec(16'd9, 1'b0, 4'd0);
    check_all("after_rstmid");

    // Randomized operations against the model
    for (int n = 0; n < 40; n++) begin
      int unsigned kind;
      logic [15:0] d;
      logic        s;
      logic [3:0]  op;
      kind = $urandom_range(2, 0);
      d    = 16'($urandom);
      s    = 1'($urandom);
      op   = 4'($urandom_range(5, 0));
      case (kind)
        0:       do_load(d, s);
        1:       do_exec(d, s, op);
        default: do_browse();
      endcase
      check_all("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
